// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch/decode front end: FSM encoding,
// opcode and nsel constants, instruction field positions, decoded-field struct.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_MOV = 3'b110;

  localparam logic [2:0] NSEL_RN = 3'b100;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b001;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 13;
  localparam int OP_MSB   = 12;
  localparam int OP_LSB   = 11;
  localparam int RN_MSB   = 10;
  localparam int RN_LSB   = 8;
  localparam int RD_MSB   = 7;
  localparam int RD_LSB   = 5;
  localparam int SH_MSB   = 4;
  localparam int SH_LSB   = 3;
  localparam int RM_MSB   = 2;
  localparam int RM_LSB   = 0;
  localparam int IMM5_MSB = 4;
  localparam int IMM8_MSB = 7;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [1:0]  shift;
    logic [15:0] sximm5;
    logic [15:0] sximm8;
    logic [2:0]  rnum;
    logic        illegal;
  } dec_t;

  // ALU accepts every op; MOV only the even op codes (00, 10).
  function automatic logic is_legal(input logic [2:0] opc, input logic [1:0] op);
    return (opc == OPC_ALU) || ((opc == OPC_MOV) && !op[0]);
  endfunction

endpackage

// File: rtl/fetch_decode_unit_if.sv
// Instruction-memory read port: request/address out, data/ready back.
interface fetch_decode_unit_if #(
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic              mem_ready;

  modport master (output mem_req, mem_addr, input  mem_rdata, mem_ready);
  modport slave  (input  mem_req, mem_addr, output mem_rdata, mem_ready);
endinterface

// File: rtl/instr_decoder.sv
// Combinational IR decode: fields, sign-extended immediates, nsel register
// mux and the illegal-instruction flag.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  input  logic [2:0]  nsel,
  output dec_t        dec
);

  always_comb begin
    dec        = '0;
    dec.opcode = ir[OPC_MSB:OPC_LSB];
    dec.op     = ir[OP_MSB:OP_LSB];
    dec.shift  = ir[SH_MSB:SH_LSB];
    dec.sximm5 = {{11{ir[IMM5_MSB]}}, ir[IMM5_MSB:0]};
    dec.sximm8 = {{8{ir[IMM8_MSB]}}, ir[IMM8_MSB:0]};
    // Non-one-hot selects read as register 0 rather than OR-ing fields.
    case (nsel)
      NSEL_RN: dec.rnum = ir[RN_MSB:RN_LSB];
      NSEL_RD: dec.rnum = ir[RD_MSB:RD_LSB];
      NSEL_RM: dec.rnum = ir[RM_MSB:RM_LSB];
      default: dec.rnum = 3'b000;
    endcase
    dec.illegal = !is_legal(dec.opcode, dec.op);
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetch/decode front end: fetches into IR, decodes, pulses s, waits on w.
// Optional retired-instruction counter under `FDU_RETIRE_CNT_EN.
module fetch_decode_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  fetch_decode_unit_if.master mem,
  output logic              s,
  input  logic              w,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  input  logic [2:0]        nsel,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic [1:0]        shift,
  output logic [15:0]       sximm5,
  output logic [15:0]       sximm8,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
`ifdef FDU_RETIRE_CNT_EN
  ,
  output logic [15:0]       retired
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  dec_t              dec;
  logic              fetch_done;

  assign fetch_done = (state_q == ST_FETCH) && mem.mem_ready;

  instr_decoder u_dec (
    .ir   (ir_q),
    .nsel (nsel),
    .dec  (dec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (run) state_d = ST_FETCH;
      ST_FETCH:  if (mem.mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (dec.illegal) state_d = ST_HALT;
        else if (w)      state_d = ST_ISSUE;
      end
      // The controller leaves its wait state on the edge ending ISSUE.
      ST_ISSUE:  state_d = ST_EXEC;
      ST_EXEC:   if (w) state_d = run ? ST_FETCH : ST_IDLE;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s           = (state_q == ST_ISSUE);
    mem.mem_req = (state_q == ST_FETCH);
    halted      = (state_q == ST_HALT);
  end

  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    if (fetch_done) begin
      pc_d = pc_q + 1'b1;
      ir_d = mem.mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
      ir_q <= 16'h0000;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end

  assign mem.mem_addr = pc_q;
  assign pc           = pc_q;
  assign opcode       = dec.opcode;
  assign op           = dec.op;
  assign shift        = dec.shift;
  assign sximm5       = dec.sximm5;
  assign sximm8       = dec.sximm8;
  assign readnum      = dec.rnum;
  assign writenum     = dec.rnum;

`ifdef FDU_RETIRE_CNT_EN
  logic [15:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if ((state_q == ST_EXEC) && w) retired_d = retired_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) retired_q <= 16'd0;
    else        retired_q <= retired_d;
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Scoreboard bench for fetch_decode_unit: directed handshake/decode/halt cases,
// then randomized memory latency, w, run and nsel against a field-level model.
module tb_fetch_decode_unit;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic          w = 1'b0;
  logic [2:0]    nsel = 3'b000;
  logic          s, halted;
  logic [2:0]    opcode, readnum, writenum;
  logic [1:0]    op, shift;
  logic [15:0]   sximm5, sximm8;
  logic [AW-1:0] pc;
`ifdef FDU_RETIRE_CNT_EN
  logic [15:0]   retired;
`endif

  fetch_decode_unit_if #(.ADDR_W(AW)) mem_if ();

  fetch_decode_unit #(.ADDR_W(AW), .RESET_PC('0)) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .mem      (mem_if),
    .s        (s),
    .w        (w),
    .opcode   (opcode),
    .op       (op),
    .nsel     (nsel),
    .readnum  (readnum),
    .writenum (writenum),
    .shift    (shift),
    .sximm5   (sximm5),
    .sximm8   (sximm8),
    .pc       (pc),
    .halted   (halted)
`ifdef FDU_RETIRE_CNT_EN
    ,
    .retired  (retired)
`endif
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_pass = 0;
  logic [15:0] exp_q[$];
  int          model_pc = 0;
  int          s_cnt = 0;
  bit          auto_mem = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: field extraction by plain arithmetic on the instruction word.
  function automatic logic [15:0] sext(input int v, input int bits);
    int r = v;
    if (v >= (1 << (bits - 1))) r = v - (1 << bits);
    return 16'(r);
  endfunction

  function automatic bit m_legal(input logic [15:0] i);
    int opc = int'(i) / 8192;
    int o   = (int'(i) / 2048) % 4;
    return (opc == 5) || (opc == 6 && (o == 0 || o == 2));
  endfunction

  function automatic logic [2:0] m_rnum(input logic [15:0] i, input logic [2:0] ns);
    if (ns == 3'b100) return 3'((int'(i) / 256) % 8);
    if (ns == 3'b010) return 3'((int'(i) / 32) % 8);
    if (ns == 3'b001) return 3'(int'(i) % 8);
    return 3'd0;
  endfunction

  function automatic logic [15:0] gen_instr();
    logic [15:0] v = 16'($urandom);
    int r = $urandom_range(0, 15);
    if (r < 7) v[15:13] = 3'b101;
    else if (r < 14) begin v[15:13] = 3'b110; v[11] = 1'b0; end
    return v;
  endfunction

  // Present one word on the bus this cycle and record what must be issued for it.
  task automatic give(input logic [15:0] v);
    chk("fetch_addr", 32'(mem_if.mem_addr), 32'(model_pc));
    exp_q.push_back(v);
    model_pc = (model_pc + 1) % (1 << AW);
    mem_if.mem_rdata = v;
    mem_if.mem_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("rst_req", mem_if.mem_req, 0);
    chk("rst_s", s, 0);
    chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_opcode", opcode, 0);
`ifdef FDU_RETIRE_CNT_EN
    chk("rst_retired", retired, 0);
`endif
    exp_q.delete();
    model_pc = 0;
    s_cnt = 0;
    mem_if.mem_ready = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
  endtask

  task automatic wait_req(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (mem_if.mem_req) break;
    end
    chk("wait_req", mem_if.mem_req, 1);
  endtask

  // Monitor: every s pulse or halt entry consumes one fetched word.
  initial begin
    logic        prev_s, prev_h;
    logic [15:0] e;
    prev_s = 1'b0;
    prev_h = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_s = 1'b0;
        prev_h = 1'b0;
      end else begin
        if (s) begin
          chk("s_width", prev_s, 0);
          if (exp_q.size() == 0) chk("s_unexpected", s, 0);
          else begin
            e = exp_q.pop_front();
            chk("issue_legal", s, m_legal(e));
            chk("opcode", opcode, int'(e) / 8192);
            chk("op", op, (int'(e) / 2048) % 4);
            chk("shift", shift, (int'(e) / 8) % 4);
            chk("sximm5", sximm5, sext(int'(e) % 32, 5));
            chk("sximm8", sximm8, sext(int'(e) % 256, 8));
            chk("readnum", readnum, m_rnum(e, nsel));
            chk("writenum", writenum, m_rnum(e, nsel));
`ifdef FDU_RETIRE_CNT_EN
            chk("retired", retired, 32'(s_cnt % 65536));
`endif
            s_cnt++;
          end
        end
        if (halted && !prev_h) begin
          if (exp_q.size() == 0) chk("halt_unexpected", halted, 0);
          else begin
            e = exp_q.pop_front();
            chk("halt_legal", m_legal(e), 0);
          end
        end
        if (halted) chk("halt_quiet", {mem_if.mem_req, s}, 0);
        prev_s = s;
        prev_h = halted;
      end
    end
  end

  // Random-latency memory model used in the randomized phase.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (auto_mem) begin
        if (mem_if.mem_req && reset && ($urandom % 3 == 0)) give(gen_instr());
        else begin
          mem_if.mem_ready = 1'b0;
          mem_if.mem_rdata = 16'($urandom);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = 16'h0000;
    #2 reset = 1'b0;
    @(negedge clk);
    chk("init_req", mem_if.mem_req, 0);
    chk("init_s", s, 0);
    chk("init_halted", halted, 0);
    chk("init_pc", pc, 0);
    chk("init_sximm8", sximm8, 0);
    @(posedge clk); #2 reset = 1'b1;

    // Stall the fetch, then reset in the middle of it.
    @(posedge clk); #1 run = 1'b1;
    wait_req(8);
    repeat (3) begin
      @(negedge clk);
      chk("hold_req", mem_if.mem_req, 1);
      chk("hold_addr", mem_if.mem_addr, 0);
    end
    do_reset();

    // Fetch handshake and issue latency.
    wait_req(8);
    repeat (3) begin
      @(negedge clk);
      chk("stall_req", mem_if.mem_req, 1);
      chk("stall_addr", mem_if.mem_addr, 0);
    end
    @(posedge clk); #1 w = 1'b1; give(16'hA0E1);
    @(posedge clk); #1 mem_if.mem_ready = 1'b0;
    @(negedge clk);
    chk("lat_pc", pc, 1);
    chk("lat_opcode", opcode, 3'b101);
    chk("lat_op", op, 0);
    chk("lat_s_d1", s, 0);
    @(negedge clk); chk("lat_s_d2", s, 1);
    @(negedge clk); chk("lat_s_d3", s, 0);

    // MOV decode with DECODE held by w=0.
    @(posedge clk); #1 w = 1'b0; give(16'hD2F6);
    @(posedge clk); #1 mem_if.mem_ready = 1'b0; nsel = 3'b100;
    @(negedge clk);
    chk("mov_opcode", opcode, 3'b110);
    chk("mov_op", op, 2'b10);
    chk("mov_sximm8", sximm8, 16'hFFF6);
    chk("mov_sximm5", sximm5, 16'hFFF6);
    chk("mov_rn", readnum, 3'b010);
    @(posedge clk); #1 nsel = 3'b011;
    @(negedge clk); chk("mov_nsel_bad", readnum, 0);
    repeat (2) begin
      @(negedge clk);
      chk("dec_wait_s", s, 0);
      chk("dec_wait_req", mem_if.mem_req, 0);
    end
    @(posedge clk); #1 w = 1'b1; nsel = 3'b010;
    @(negedge clk); chk("dec_go_s0", s, 0);
    @(posedge clk); #1 w = 1'b0; run = 1'b0;
    @(negedge clk); chk("dec_go_s1", s, 1);
    repeat (3) begin
      @(negedge clk);
      chk("exec_wait_s", s, 0);
      chk("exec_wait_req", mem_if.mem_req, 0);
    end
    @(posedge clk); #1 w = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_req", mem_if.mem_req, 0);
    end
    @(posedge clk); #1 w = 1'b0;

    // Illegal opcode traps until reset.
    @(posedge clk); #1 run = 1'b1;
    wait_req(8);
    @(posedge clk); #1 w = 1'b1; give(16'h2000);
    @(posedge clk); #1 mem_if.mem_ready = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("ill_s", s, 0);
      chk("ill_req", mem_if.mem_req, 0);
    end
    chk("ill_halted", halted, 1);
    do_reset();

    // Randomized run: memory latency, w, run and nsel all random.
    auto_mem = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      w = 1'($urandom % 2);
      run = ($urandom % 8) != 0;
      case ($urandom % 4)
        0: nsel = 3'b100;
        1: nsel = 3'b010;
        2: nsel = 3'b001;
        default: nsel = 3'($urandom);
      endcase
      if (halted) do_reset();
    end
    auto_mem = 1'b0;
    mem_if.mem_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
